// File: rtl/my_fifo_sync_if.sv
// Bus bundle for my_fifo_sync: write/read requests, read data, occupancy and status.
//
// Handshake: wr_en and rd_en are requests sampled on the rising edge of clk.
// A write is taken when wr_en && !full, and a read when rd_en && !empty.
// full and empty are the values seen before that edge, so they act as the
// inverted ready of each side. A refused request is dropped, not held
// pending. It raises wrerr/rderr for the following cycle.
interface my_fifo_sync_if #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 9
);
    logic [WIDTH-1:0]    din;
    logic                wr_en;
    logic                rd_en;
    logic [WIDTH-1:0]    dout;
    logic                full;
    logic                empty;
    logic                almostfull;
    logic                almostempty;
    logic [DEPTH_LOG2:0] count;
    logic                wrerr;
    logic                rderr;

    // Requester side: drives data and requests, observes data and status.
    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, almostfull, almostempty, count, wrerr, rderr
    );

    // FIFO side.
    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, almostfull, almostempty, count, wrerr, rderr
    );
endinterface

// File: rtl/my_fifo_sync.sv
// Single-clock FIFO on inferred RAM with occupancy count, almost-full/almost-empty
// thresholds, optional first-word-fall-through output and registered error pulses.
module my_fifo_sync #(
    parameter int WIDTH               = 9,
    parameter int DEPTH_LOG2          = 9,
    parameter int FWFT                = 0,
    parameter int ALMOST_FULL_OFFSET  = 128,
    parameter int ALMOST_EMPTY_OFFSET = 128
) (
    input  logic           clk,
    input  logic           rst,
    my_fifo_sync_if.slave  bus
);
    localparam int CW          = DEPTH_LOG2 + 1;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int AF_LEVEL_I  = DEPTH - ALMOST_FULL_OFFSET;
    localparam int AE_LEVEL_I  = ALMOST_EMPTY_OFFSET;

    localparam logic [CW-1:0] DEPTH_C  = DEPTH[CW-1:0];
    localparam logic [CW-1:0] AF_LEVEL = AF_LEVEL_I[CW-1:0];
    localparam logic [CW-1:0] AE_LEVEL = AE_LEVEL_I[CW-1:0];
    localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
    logic [CW-1:0]         count_q;
    logic [WIDTH-1:0]      dout_q;
    logic                  wrerr_q;
    logic                  rderr_q;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    assign full_w     = (count_q == DEPTH_C);
    assign empty_w    = (count_q == '0);
    // A pop never frees a slot for a write on the same edge, and vice versa.
    assign wr_acc     = bus.wr_en && !full_w;
    assign rd_acc     = bus.rd_en && !empty_w;
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    // Storage write; contents are never cleared, reset only makes them unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers and occupancy; simultaneous accepted read and write leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

    // Output register. Standard mode loads the head on an accepted read.
    // FWFT keeps the head on dout: a write into an empty FIFO (or into a FIFO whose
    // only word is popped the same edge) bypasses din; a pop with more words left
    // fetches the entry behind the head; otherwise dout holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (FWFT == 0) begin
            if (rd_acc) begin
                dout_q <= mem[rd_ptr];
            end
        end else begin
            if (wr_acc && (empty_w || (rd_acc && count_q == ONE_C))) begin
                dout_q <= bus.din;
            end else if (rd_acc && count_q > ONE_C) begin
                dout_q <= mem[rd_ptr_nxt];
            end
        end
    end

    // Error pulses: high for the cycle after each refused request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrerr_q <= 1'b0;
            rderr_q <= 1'b0;
        end else begin
            wrerr_q <= bus.wr_en && full_w;
            rderr_q <= bus.rd_en && empty_w;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almostfull  = (count_q >= AF_LEVEL);
    assign bus.almostempty = (count_q <= AE_LEVEL);
    assign bus.wrerr       = wrerr_q;
    assign bus.rderr       = rderr_q;
endmodule

// File: tb/tb_my_fifo_sync.sv
// Bench for my_fifo_sync: a standard-mode and an FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_my_fifo_sync;
    localparam int W   = 36;
    localparam int DL  = 4;
    localparam int DEP = 16;
    localparam int AFO = 2;
    localparam int AEO = 3;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  din   = '0;

    my_fifo_sync_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if_std ();
    my_fifo_sync_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if_fwft ();

    assign if_std.din    = din;
    assign if_std.wr_en  = wr_en;
    assign if_std.rd_en  = rd_en;
    assign if_fwft.din   = din;
    assign if_fwft.wr_en = wr_en;
    assign if_fwft.rd_en = rd_en;

    my_fifo_sync #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(0),
                   .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO))
        u_std (.clk(clk), .rst(rst), .bus(if_std));

    my_fifo_sync #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(1),
                   .ALMOST_FULL_OFFSET(AFO), .ALMOST_EMPTY_OFFSET(AEO))
        u_fwft (.clk(clk), .rst(rst), .bus(if_fwft));

    // Scoreboard: expected FIFO contents and expected registered outputs
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout_std  = '0;
    logic [W-1:0] exp_dout_fwft = '0;
    logic         exp_wrerr     = 1'b0;
    logic         exp_rderr     = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the pre-edge contents.
    task automatic model_edge(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
        int n;
        logic wacc;
        logic racc;
        if (r) begin
            exp_q.delete();
            exp_dout_std  = '0;
            exp_dout_fwft = '0;
            exp_wrerr     = 1'b0;
            exp_rderr     = 1'b0;
        end else begin
            n         = exp_q.size();
            wacc      = w && (n < DEP);
            racc      = rd && (n > 0);
            exp_wrerr = w && (n == DEP);
            exp_rderr = rd && (n == 0);
            if (racc) exp_dout_std = exp_q.pop_front();
            if (wacc) exp_q.push_back(d);
            if (exp_q.size() > 0) exp_dout_fwft = exp_q[0];
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check("std_count", 64'(if_std.count), 64'(n));
        check("std_empty", 64'(if_std.empty), 64'(n == 0));
        check("std_full", 64'(if_std.full), 64'(n == DEP));
        check("std_afull", 64'(if_std.almostfull), 64'(n >= DEP - AFO));
        check("std_aempty", 64'(if_std.almostempty), 64'(n <= AEO));
        check("std_wrerr", 64'(if_std.wrerr), 64'(exp_wrerr));
        check("std_rderr", 64'(if_std.rderr), 64'(exp_rderr));
        check("std_dout", 64'(if_std.dout), 64'(exp_dout_std));
        check("fwft_count", 64'(if_fwft.count), 64'(n));
        check("fwft_empty", 64'(if_fwft.empty), 64'(n == 0));
        check("fwft_wrerr", 64'(if_fwft.wrerr), 64'(exp_wrerr));
        check("fwft_rderr", 64'(if_fwft.rderr), 64'(exp_rderr));
        check("fwft_dout", 64'(if_fwft.dout), 64'(exp_dout_fwft));
    endtask

    // Driver: apply inputs for one cycle, update the model at the edge, check after it.
    task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        model_edge(r, w, rd, d);
        #1;
        check_all();
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[W-1:0];
    endfunction

    initial begin
        #1;
        // Reset held for 3 cycles with a write request asserted
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 36'h123456789);
        step(1'b0, 1'b0, 1'b0, '0);
        check("rst_count", 64'(if_std.count), 64'd0);
        check("rst_empty", 64'(if_std.empty), 64'd1);
        check("rst_full", 64'(if_std.full), 64'd0);
        check("rst_aempty", 64'(if_std.almostempty), 64'd1);
        check("rst_dout", 64'(if_std.dout), 64'd0);
        check("rst_errs", 64'({if_std.wrerr, if_std.rderr}), 64'd0);

        // Fill 0..15: almostfull after the 14th write, full after the 16th
        for (int i = 0; i < DEP; i++) begin
            step(1'b0, 1'b1, 1'b0, W'(i));
            check("fill_afull", 64'(if_std.almostfull), 64'((i + 1) >= 14));
            check("fill_full", 64'(if_std.full), 64'((i + 1) == 16));
        end
        step(1'b0, 1'b1, 1'b0, W'(99));
        check("ovf_wrerr", 64'(if_std.wrerr), 64'd1);
        check("ovf_count", 64'(if_std.count), 64'd16);
        step(1'b0, 1'b0, 1'b0, '0);
        check("ovf_wrerr_drop", 64'(if_std.wrerr), 64'd0);

        // Drain: data comes back 0..15, then one underflow
        for (int i = 0; i < DEP; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            check("drain_dout", 64'(if_std.dout), 64'(i));
        end
        step(1'b0, 1'b0, 1'b1, '0);
        check("unf_rderr", 64'(if_std.rderr), 64'd1);
        check("unf_dout", 64'(if_std.dout), 64'd15);
        check("unf_empty", 64'(if_std.empty), 64'd1);

        // Fill to 8, then 40 cycles of simultaneous write and read across wraps
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, W'(i));
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, 1'b1, W'(8 + k));
            check("stream_dout", 64'(if_std.dout), 64'(k));
            check("stream_count", 64'(if_std.count), 64'd8);
            check("stream_flags", 64'({if_std.full, if_std.empty, if_std.almostfull, if_std.almostempty}), 64'd0);
        end

        // FWFT: a write into an empty FIFO appears on dout the next cycle
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, W'(36'ha5));
        check("fwft_first_empty", 64'(if_fwft.empty), 64'd0);
        check("fwft_first_dout", 64'(if_fwft.dout), 64'ha5);
        step(1'b0, 1'b1, 1'b0, W'(36'h3c));
        step(1'b0, 1'b0, 1'b1, '0);
        check("fwft_pop_dout", 64'(if_fwft.dout), 64'h3c);
        step(1'b0, 1'b0, 1'b1, '0);
        check("fwft_pop_empty", 64'(if_fwft.empty), 64'd1);

        // Mid-operation reset with count around 10 and toggling requests
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, rand_word());
        for (int k = 0; k < 6; k++) step(1'b0, k[0], ~k[0], rand_word());
        step(1'b1, 1'b1, 1'b1, rand_word());
        check("midrst_count", 64'(if_std.count), 64'd0);
        check("midrst_empty", 64'(if_std.empty), 64'd1);
        step(1'b0, 1'b1, 1'b0, W'(36'h5a));
        check("midrst_fwft_dout", 64'(if_fwft.dout), 64'h5a);
        step(1'b0, 1'b0, 1'b1, '0);
        check("midrst_std_dout", 64'(if_std.dout), 64'h5a);

        // Random traffic, alternating write-heavy and read-heavy phases, rare resets
        for (int c = 0; c < 3000; c++) begin
            logic r;
            logic w;
            logic rd;
            logic heavy_wr;
            heavy_wr = ((c / 300) % 2) == 0;
            r  = ($urandom_range(0, 249) == 0);
            w  = heavy_wr ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rd = heavy_wr ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            step(r, w, rd, rand_word());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
